// File: rtl/shifter_pkg.sv
// Shared opcode encodings and controller state type for the shift unit.
package shifter_pkg;

  localparam logic [2:0] OpHold  = 3'b000;
  localparam logic [2:0] OpClear = 3'b001;
  localparam logic [2:0] OpLoad  = 3'b010;
  localparam logic [2:0] OpShl   = 3'b011;
  localparam logic [2:0] OpShr   = 3'b100;
  localparam logic [2:0] OpRol   = 3'b101;
  localparam logic [2:0] OpRor   = 3'b110;
  localparam logic [2:0] OpAsr   = 3'b111;

  typedef enum logic {
    StIdle = 1'b0,
    StBusy = 1'b1
  } state_e;

  // Opcodes from SHL upward are the multi-cycle shift/rotate commands.
  function automatic logic is_shift_op(logic [2:0] op);
    return op >= OpShl;
  endfunction

endpackage

// File: rtl/shift_step.sv
// Combinational single-bit shift/rotate step used once per busy cycle.
module shift_step
  import shifter_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic [2:0]       op_i,
  input  logic [WIDTH-1:0] value_i,
  input  logic             serial_i,
  output logic [WIDTH-1:0] value_o,
  output logic             out_o
);

  always_comb begin
    value_o = value_i;
    out_o   = 1'b0;
    case (op_i)
      OpShl: begin
        value_o = {value_i[WIDTH-2:0], serial_i};
        out_o   = value_i[WIDTH-1];
      end
      OpShr: begin
        value_o = {serial_i, value_i[WIDTH-1:1]};
        out_o   = value_i[0];
      end
      OpRol: begin
        value_o = {value_i[WIDTH-2:0], value_i[WIDTH-1]};
        out_o   = value_i[WIDTH-1];
      end
      OpRor: begin
        value_o = {value_i[0], value_i[WIDTH-1:1]};
        out_o   = value_i[0];
      end
      OpAsr: begin
        value_o = {value_i[WIDTH-1], value_i[WIDTH-1:1]};
        out_o   = value_i[0];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/shift_unit.sv
// Multi-cycle shift register unit: single-cycle HOLD/CLEAR/LOAD, N-cycle shifts/rotates.
module shift_unit
  import shifter_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned AMT_W = $clog2(WIDTH)
) (
  input  logic             clockShifter,
  input  logic             resetShifter,
  input  logic             validShifter,
  input  logic [2:0]       comandShifter,
  input  logic [AMT_W-1:0] amountShifter,
  input  logic [WIDTH-1:0] inputShifter,
  input  logic             serialInShifter,
  output logic             readyShifter,
  output logic             doneShifter,
  output logic [WIDTH-1:0] valueShifter,
  output logic             serialOutShifter
);

  state_e             state_q, state_d;
  logic [2:0]         op_q, op_d;
  logic [AMT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   value_q, value_d;
  logic               sout_q, sout_d;
  logic               done_q, done_d;
  logic [WIDTH-1:0]   step_value;
  logic               step_out;

  shift_step #(
    .WIDTH(WIDTH)
  ) u_shift_step (
    .op_i    (op_q),
    .value_i (value_q),
    .serial_i(serialInShifter),
    .value_o (step_value),
    .out_o   (step_out)
  );

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    value_d = value_q;
    sout_d  = sout_q;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (validShifter) begin
          if (is_shift_op(comandShifter) && (amountShifter != '0)) begin
            op_d    = comandShifter;
            cnt_d   = amountShifter;
            state_d = StBusy;
          end else begin
            // Zero-length shifts fall through here and behave as HOLD.
            done_d = 1'b1;
            case (comandShifter)
              OpClear: begin
                value_d = '0;
                sout_d  = 1'b0;
              end
              OpLoad:  value_d = inputShifter;
              default: ;
            endcase
          end
        end
      end
      StBusy: begin
        value_d = step_value;
        sout_d  = step_out;
        cnt_d   = cnt_q - AMT_W'(1);
        if (cnt_q == AMT_W'(1)) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(negedge clockShifter) begin
    if (!resetShifter) begin
      state_q <= StIdle;
      op_q    <= OpHold;
      cnt_q   <= '0;
      value_q <= '0;
      sout_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      value_q <= value_d;
      sout_q  <= sout_d;
      done_q  <= done_d;
    end
  end

  assign readyShifter     = (state_q == StIdle);
  assign doneShifter      = done_q;
  assign valueShifter     = value_q;
  assign serialOutShifter = sout_q;

endmodule

// File: tb/tb_shift_unit.sv
// Self-checking bench for shift_unit (WIDTH=8) against a whole-command arithmetic model.
module tb_shift_unit;

  localparam int W = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       valid = 1'b0;
  logic [2:0] cmd = 3'd0;
  logic [2:0] amt = 3'd0;
  logic [7:0] din = 8'd0;
  logic       sin = 1'b0;
  logic       ready, done, sout;
  logic [7:0] value;

  int chk_cnt = 0;
  int pass_cnt = 0;

  logic [7:0] m_val = 8'd0;
  logic       m_out = 1'b0;

  shift_unit #(
    .WIDTH(8),
    .AMT_W(3)
  ) dut (
    .clockShifter    (clk),
    .resetShifter    (rst_n),
    .validShifter    (valid),
    .comandShifter   (cmd),
    .amountShifter   (amt),
    .inputShifter    (din),
    .serialInShifter (sin),
    .readyShifter    (ready),
    .doneShifter     (done),
    .valueShifter    (value),
    .serialOutShifter(sout)
  );

  always #5 clk = ~clk;

  // Applies a whole command at once: shift by N in one arithmetic expression.
  task automatic model_apply(input logic [2:0] op, input int n, input logic [7:0] d,
                             input logic s);
    int unsigned v;
    logic signed [7:0] sv;
    v = m_val;
    if (op >= 3 && n != 0) begin
      case (op)
        3: begin
          m_out = 1'((v >> (W - n)) & 1);
          m_val = 8'(((v << n) | (s ? ((1 << n) - 1) : 0)) & 255);
        end
        4: begin
          m_out = 1'((v >> (n - 1)) & 1);
          m_val = 8'((v >> n) | (s ? ((255 << (W - n)) & 255) : 0));
        end
        5: begin
          m_val = 8'(((v << n) | (v >> (W - n))) & 255);
          m_out = m_val[0];
        end
        6: begin
          m_val = 8'(((v >> n) | (v << (W - n))) & 255);
          m_out = m_val[7];
        end
        default: begin
          sv    = m_val;
          m_val = 8'(sv >>> n);
          m_out = 1'((v >> (n - 1)) & 1);
        end
      endcase
    end else if (op == 3'd1) begin
      m_val = 8'd0;
      m_out = 1'b0;
    end else if (op == 3'd2) begin
      m_val = d;
    end
  endtask

  // Issues one command and observes a fixed 12-cycle window after the accept edge.
  task automatic issue(input logic [2:0] op, input logic [2:0] n, input logic [7:0] d,
                       input logic s, output int lat, output int dones, output int rlow);
    @(posedge clk);
    valid = 1'b1; cmd = op; amt = n; din = d; sin = s;
    @(posedge clk);
    valid = 1'b0; cmd = 3'($urandom); amt = 3'($urandom); din = 8'($urandom);
    lat = 0; dones = 0; rlow = 0;
    for (int k = 1; k <= 12; k++) begin
      if (k > 1) @(posedge clk);
      if (done) begin
        dones++;
        if (lat == 0) lat = k;
      end
      if (!ready) rlow++;
    end
  endtask

  task automatic test_reset();
    int lat, dones, rlow;
    repeat (2) @(posedge clk);
    rst_n = 1'b1;
    issue(3'd2, 3'd0, 8'h3C, 1'b0, lat, dones, rlow);
    chk_cnt++;
    if (value !== 8'h3C) $display("FAIL reset_preload value=%h want=3c", value);
    else pass_cnt++;
    @(posedge clk);
    rst_n = 1'b0; valid = 1'b1; cmd = 3'd2; din = 8'h55;
    @(posedge clk);
    rst_n = 1'b1; valid = 1'b0;
    chk_cnt++;
    if (value !== 8'h00) $display("FAIL reset_value value=%h want=00", value);
    else pass_cnt++;
    chk_cnt++;
    if (ready !== 1'b1) $display("FAIL reset_ready ready=%b want=1", ready);
    else pass_cnt++;
    chk_cnt++;
    if (done !== 1'b0) $display("FAIL reset_done done=%b want=0", done);
    else pass_cnt++;
    chk_cnt++;
    if (sout !== 1'b0) $display("FAIL reset_sout sout=%b want=0", sout);
    else pass_cnt++;
    m_val = 8'h00; m_out = 1'b0;
  endtask

  task automatic test_load();
    int lat, dones, rlow;
    issue(3'd2, 3'd0, 8'hA5, 1'b0, lat, dones, rlow);
    model_apply(3'd2, 0, 8'hA5, 1'b0);
    chk_cnt++;
    if (value !== 8'hA5) $display("FAIL load_value value=%h want=a5", value);
    else pass_cnt++;
    chk_cnt++;
    if (lat !== 1 || dones !== 1) $display("FAIL load_done lat=%0d dones=%0d want=1/1", lat, dones);
    else pass_cnt++;
    chk_cnt++;
    if (rlow !== 0) $display("FAIL load_ready ready_low_cycles=%0d want=0", rlow);
    else pass_cnt++;
  endtask

  task automatic test_shl();
    int lat, dones, rlow;
    issue(3'd3, 3'd3, 8'h00, 1'b1, lat, dones, rlow);
    model_apply(3'd3, 3, 8'h00, 1'b1);
    chk_cnt++;
    if (value !== 8'h2F || sout !== 1'b1)
      $display("FAIL shl_result value=%h sout=%b want=2f/1", value, sout);
    else pass_cnt++;
    chk_cnt++;
    if (rlow !== 3 || lat !== 4 || dones !== 1)
      $display("FAIL shl_timing rlow=%0d lat=%0d dones=%0d want=3/4/1", rlow, lat, dones);
    else pass_cnt++;
  endtask

  task automatic test_asr_ror();
    int lat, dones, rlow;
    issue(3'd2, 3'd0, 8'h84, 1'b0, lat, dones, rlow);
    model_apply(3'd2, 0, 8'h84, 1'b0);
    issue(3'd7, 3'd2, 8'h00, 1'b0, lat, dones, rlow);
    model_apply(3'd7, 2, 8'h00, 1'b0);
    chk_cnt++;
    if (value !== 8'hE1 || lat !== 3) $display("FAIL asr value=%h lat=%0d want=e1/3", value, lat);
    else pass_cnt++;
    issue(3'd2, 3'd0, 8'h01, 1'b0, lat, dones, rlow);
    model_apply(3'd2, 0, 8'h01, 1'b0);
    issue(3'd6, 3'd1, 8'h00, 1'b0, lat, dones, rlow);
    model_apply(3'd6, 1, 8'h00, 1'b0);
    chk_cnt++;
    if (value !== 8'h80 || sout !== 1'b1)
      $display("FAIL ror value=%h sout=%b want=80/1", value, sout);
    else pass_cnt++;
  endtask

  task automatic test_busy_ignore();
    int lat, dones, rlow, lat_d;
    issue(3'd2, 3'd0, 8'hB6, 1'b0, lat, dones, rlow);
    model_apply(3'd2, 0, 8'hB6, 1'b0);
    @(posedge clk);
    valid = 1'b1; cmd = 3'd4; amt = 3'd7; sin = 1'b0;
    @(posedge clk);
    valid = 1'b1; cmd = 3'd2; din = 8'hFF;
    chk_cnt++;
    if (ready !== 1'b0) $display("FAIL busy_ready ready=%b want=0", ready);
    else pass_cnt++;
    lat_d = 0;
    for (int k = 2; k <= 12; k++) begin
      @(posedge clk);
      valid = 1'b0;
      if (done && lat_d == 0) lat_d = k;
    end
    model_apply(3'd4, 7, 8'h00, 1'b0);
    chk_cnt++;
    if (value !== m_val || lat_d !== 8)
      $display("FAIL busy_ignore value=%h lat=%0d want=%h/8", value, lat_d, m_val);
    else pass_cnt++;
  endtask

  task automatic test_reset_midop();
    int lat, dones, rlow, late_done;
    issue(3'd2, 3'd0, 8'hFF, 1'b0, lat, dones, rlow);
    @(posedge clk);
    valid = 1'b1; cmd = 3'd4; amt = 3'd7; sin = 1'b0;
    @(posedge clk);
    valid = 1'b0;
    repeat (2) @(posedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    rst_n = 1'b1;
    m_val = 8'h00; m_out = 1'b0;
    chk_cnt++;
    if (value !== 8'h00 || ready !== 1'b1 || done !== 1'b0 || sout !== 1'b0)
      $display("FAIL midop_reset value=%h ready=%b done=%b sout=%b want=00/1/0/0",
               value, ready, done, sout);
    else pass_cnt++;
    late_done = 0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      if (done) late_done++;
    end
    chk_cnt++;
    if (late_done !== 0) $display("FAIL midop_nodone dones=%0d want=0", late_done);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    @(posedge clk);
    valid = 1'b1; cmd = 3'd2; din = 8'h5A;
    @(posedge clk);
    model_apply(3'd2, 0, 8'h5A, 1'b0);
    chk_cnt++;
    if (done !== 1'b1) $display("FAIL b2b_first_done done=%b want=1", done);
    else pass_cnt++;
    cmd = 3'd3; amt = 3'd1; sin = 1'b0;
    @(posedge clk);
    valid = 1'b0;
    chk_cnt++;
    if (done !== 1'b0 || ready !== 1'b0)
      $display("FAIL b2b_busy done=%b ready=%b want=0/0", done, ready);
    else pass_cnt++;
    @(posedge clk);
    model_apply(3'd3, 1, 8'h00, 1'b0);
    chk_cnt++;
    if (done !== 1'b1 || value !== m_val || sout !== m_out)
      $display("FAIL b2b_second done=%b value=%h sout=%b want=1/%h/%b",
               done, value, sout, m_val, m_out);
    else pass_cnt++;
    @(posedge clk);
    chk_cnt++;
    if (done !== 1'b0) $display("FAIL b2b_pulse_end done=%b want=0", done);
    else pass_cnt++;
  endtask

  task automatic test_random();
    int lat, dones, rlow, exp_lat, exp_rlow;
    logic [2:0] op, n;
    logic [7:0] d;
    logic s;
    for (int i = 0; i < 20; i++) begin
      op = 3'($urandom); n = 3'($urandom); d = 8'($urandom); s = 1'($urandom);
      issue(op, n, d, s, lat, dones, rlow);
      model_apply(op, int'(n), d, s);
      exp_lat  = (op >= 3 && n != 0) ? int'(n) + 1 : 1;
      exp_rlow = (op >= 3 && n != 0) ? int'(n) : 0;
      chk_cnt++;
      if (value !== m_val || sout !== m_out)
        $display("FAIL rand_result i=%0d op=%0d n=%0d value=%h sout=%b want=%h/%b",
                 i, op, n, value, sout, m_val, m_out);
      else pass_cnt++;
      chk_cnt++;
      if (lat !== exp_lat || dones !== 1 || rlow !== exp_rlow)
        $display("FAIL rand_timing i=%0d op=%0d n=%0d lat=%0d dones=%0d rlow=%0d want=%0d/1/%0d",
                 i, op, n, lat, dones, rlow, exp_lat, exp_rlow);
      else pass_cnt++;
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_shl();
    test_asr_ror();
    test_busy_ignore();
    test_reset_midop();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/shift_unit.md
SHIFT_UNIT -- requirements
Module: shift_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning data register width in bits (>=2).
REQ-002 SHALL have parameter AMT_W, default $clog2(WIDTH), meaning shift-amount field width.
REQ-003 SHALL have port clockShifter  input  1  the single clock; all state updates on its falling edge.
REQ-004 SHALL have port resetShifter  input  1  reset, synchronous and active-low.
REQ-005 SHALL have port validShifter  input  1  command strobe.
REQ-006 SHALL have port comandShifter  input  3  opcode.
REQ-007 SHALL have port amountShifter  input  AMT_W  shift count N (0..WIDTH-1).
REQ-008 SHALL have port inputShifter  input  WIDTH  parallel load data.
REQ-009 SHALL have port serialInShifter  input  1  fill bit for SHL/SHR.
REQ-010 SHALL have port readyShifter  output  1  high when idle and able to accept.
REQ-011 SHALL have port doneShifter  output  1  one-cycle completion pulse.
REQ-012 SHALL have port valueShifter  output  WIDTH  register contents.
REQ-013 SHALL have port serialOutShifter  output  1  bit most recently shifted or rotated out.

Function
REQ-014 SHALL decode the opcodes as: 000 HOLD, 001 CLEAR, 010 LOAD, 011 SHL, 100 SHR, 101 ROL, 110 ROR, 111 ASR.
REQ-015 SHALL accept a command on a falling edge where validShifter=1 and readyShifter=1; validShifter while busy SHALL be ignored, not queued.
REQ-016 SHALL execute HOLD, CLEAR (value<=0, serialOut<=0) and LOAD (value<=inputShifter) on the accept edge, then assert doneShifter for the next cycle; readyShifter stays 1 throughout.
REQ-017 SHALL treat a shift or rotate with N=0 as HOLD (done pulse, no change).
REQ-018 SHALL, on accepting a shift or rotate with N>=1, latch the opcode and N, enter BUSY, drop readyShifter, and leave value unchanged on that edge.
REQ-019 SHALL, in BUSY, perform exactly one 1-bit step per falling edge and decrement the counter; on the edge where the counter goes 1->0, return to IDLE and pulse doneShifter for the following cycle (total latency N+1 edges).
REQ-020 SHALL implement the steps as: SHL -> {value[W-2:0], serialIn}, out=value[W-1]; SHR -> {serialIn, value[W-1:1]}, out=value[0]; ROL/ROR -> rotate by 1, out=the wrapped bit; ASR -> {value[W-1], value[W-1:1]}, out=value[0].
REQ-021 SHALL sample serialInShifter live on each step edge; inputShifter, comandShifter and amountShifter SHALL be sampled only on the accept edge.
REQ-022 SHALL implement an FSM with exactly two states: IDLE (ready=1) and BUSY (ready=0); readyShifter SHALL be a direct decode of the state.
REQ-023 SHALL never assert doneShifter for more than one consecutive cycle per command; a new command accepted in the done cycle SHALL be legal.

Reset
REQ-024 SHALL, on a falling edge with resetShifter=0, set value=0, serialOut=0, done=0, counter=0 and state=IDLE (readyShifter=1), regardless of other inputs.
REQ-025 SHALL, when reset occurs mid-BUSY, abort the operation without a done pulse.

Structure
REQ-026 SHALL define the opcode localparams and the IDLE/BUSY state encoding in shared package shifter_pkg.
REQ-027 SHALL place the combinational 1-bit step (opcode, value, serialIn -> next value, out bit) in sub-module shift_step.

Verification (WIDTH=8)
REQ-028 SHALL cover reset: value=0x3C, hold resetShifter=0 for one edge -> value=0x00, ready=1, done=0, serialOut=0.
REQ-029 SHALL cover load: LOAD 0xA5 -> value=0xA5 after 1 edge, done=1 for exactly one cycle, ready never drops.
REQ-030 SHALL cover SHL: from 0xA5, SHL N=3, serialIn=1 -> ready low 3 cycles, value=0x2F, serialOut=1, done after edge 4.
REQ-031 SHALL cover ASR and ROR: from 0x84, ASR N=2 -> 0xE1; then from 0x01, ROR N=1 -> 0x80, serialOut=1.
REQ-032 SHALL cover busy-ignore: during SHR N=7, pulse valid with LOAD 0xFF -> load ignored, SHR completes normally.
REQ-033 SHALL cover reset mid-op: from 0xFF, SHR N=7, reset after 2 steps -> value=0x00, ready=1, no done pulse.
